// File: rtl/spi_angle_reader.sv
`default_nettype none
// ============================================================================
//  Module      : spi_angle_reader
//  Description : Periodically reads one register of an SPI accelerometer
//                (mode 3) and turns the signed Y-axis byte into an
//                offset-binary tilt value (128 = level) for the servo PWM
//                stage.
//
//                Ports:
//                  clk      system clock (100 MHz nominal)
//                  rst      synchronous, active-high reset
//                  miso     serial data from the sensor
//                  sclk     SPI clock, idles high (CPOL=1, CPHA=1)
//                  cs_n     SPI chip select, active low
//                  mosi     serial data to the sensor
//                  y_angle  offset-binary tilt, held between updates
//                  y_valid  one-cycle pulse when y_angle updates
//                  busy     high for the whole transaction
//
//                Parameters:
//                  CLK_DIV      SCLK half-period in clk cycles (2..255)
//                  POLL_CYCLES  clk cycles between transaction starts
//                  REG_ADDR     sensor register holding the Y-axis byte
//
//                Build option:
//                  ANGLE_AVG_EN  when defined, y_angle is the mean of the
//                                last four converted samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_angle_reader #(
    parameter int         CLK_DIV     = 50,
    parameter int         POLL_CYCLES = 2000000,
    parameter logic [7:0] REG_ADDR    = 8'h34
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       miso,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    output logic [7:0] y_angle,
    output logic       y_valid,
    output logic       busy
);

    localparam int             c_POLL_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(POLL_CYCLES - 1);
    localparam logic [7:0]     c_DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0]     c_HALF_LAST = 5'd31;
    // Read command (bit7 = read, bit6 = single byte) followed by a dummy byte
    // during which the sensor returns the register contents.
    localparam logic [15:0]    c_TX_WORD   = {2'b10, REG_ADDR[5:0], 8'h00};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CS_SETUP = 3'd1,
        S_SHIFT    = 3'd2,
        S_CS_HOLD  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_POLL_W-1:0]   r_poll,  w_poll_nxt;
    logic [7:0]            r_div,   w_div_nxt;
    logic [4:0]            r_half,  w_half_nxt;
    logic [15:0]           r_tx,    w_tx_nxt;
    logic [7:0]            r_rx,    w_rx_nxt;
    logic                  r_sclk,  w_sclk_nxt;
    logic                  r_cs_n,  w_cs_n_nxt;
    logic                  r_mosi,  w_mosi_nxt;
    logic                  r_busy,  w_busy_nxt;
    logic [7:0]            r_y,     w_y_nxt;
    logic                  r_valid, w_valid_nxt;

    logic                  w_poll_tick;
    logic                  w_div_done;
    logic [7:0]            w_sample;

    assign w_poll_tick = (r_poll == c_POLL_LAST);
    assign w_div_done  = (r_div == c_DIV_LAST);
    // Two's complement to offset binary is a flip of the sign bit.
    assign w_sample    = r_rx ^ 8'h80;

`ifdef ANGLE_AVG_EN
    // r_hist[0] is the most recent sample.
    logic [7:0] r_hist [0:3];
    logic [9:0] w_sum;
    logic       w_hist_load;

    assign w_sum       = {2'b00, w_sample} + {2'b00, r_hist[0]} +
                         {2'b00, r_hist[1]} + {2'b00, r_hist[2]};
    assign w_hist_load = (r_state == S_CS_HOLD) && w_div_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist[0] <= 8'd128;
            r_hist[1] <= 8'd128;
            r_hist[2] <= 8'd128;
            r_hist[3] <= 8'd128;
        end else if (w_hist_load) begin
            r_hist[0] <= w_sample;
            r_hist[1] <= r_hist[0];
            r_hist[2] <= r_hist[1];
            r_hist[3] <= r_hist[2];
        end
    end
`endif

    // Next-state and next-output logic. Outputs are registered from these
    // next values so sclk/cs_n/mosi are glitch-free and line up with the
    // state they belong to.
    always_comb begin
        w_state_nxt = r_state;
        // The poll counter free-runs so starts stay exactly POLL_CYCLES apart;
        // a tick seen outside IDLE is simply ignored.
        w_poll_nxt  = w_poll_tick ? '0 : r_poll + 1'b1;
        w_div_nxt   = r_div;
        w_half_nxt  = r_half;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_sclk_nxt  = r_sclk;
        w_cs_n_nxt  = r_cs_n;
        w_mosi_nxt  = r_mosi;
        w_busy_nxt  = r_busy;
        w_y_nxt     = r_y;
        w_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_poll_tick) begin
                    w_state_nxt = S_CS_SETUP;
                    w_cs_n_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_sclk_nxt  = 1'b1;
                    w_div_nxt   = '0;
                    w_tx_nxt    = c_TX_WORD;
                end
            end

            S_CS_SETUP: begin
                w_div_nxt = r_div + 1'b1;
                if (w_div_done) begin
                    // First SCLK fall: present the command MSB.
                    w_state_nxt = S_SHIFT;
                    w_div_nxt   = '0;
                    w_half_nxt  = '0;
                    w_sclk_nxt  = 1'b0;
                    w_mosi_nxt  = r_tx[15];
                    w_tx_nxt    = {r_tx[14:0], 1'b0};
                end
            end

            S_SHIFT: begin
                w_div_nxt = r_div + 1'b1;
                if (w_div_done) begin
                    w_div_nxt = '0;
                    if (r_half == c_HALF_LAST) begin
                        // Last high phase complete; sclk stays high.
                        w_state_nxt = S_CS_HOLD;
                    end else begin
                        w_half_nxt = r_half + 1'b1;
                        if (!r_half[0]) begin
                            // Rising edge: sample. The 8-bit shifter keeps
                            // only the last eight bits, i.e. the data byte.
                            w_sclk_nxt = 1'b1;
                            w_rx_nxt   = {r_rx[6:0], miso};
                        end else begin
                            // Falling edge: next MOSI bit.
                            w_sclk_nxt = 1'b0;
                            w_mosi_nxt = r_tx[15];
                            w_tx_nxt   = {r_tx[14:0], 1'b0};
                        end
                    end
                end
            end

            S_CS_HOLD: begin
                w_div_nxt = r_div + 1'b1;
                if (w_div_done) begin
                    w_state_nxt = S_DONE;
                    w_div_nxt   = '0;
                    w_cs_n_nxt  = 1'b1;
                    w_valid_nxt = 1'b1;
`ifdef ANGLE_AVG_EN
                    w_y_nxt     = w_sum[9:2];
`else
                    w_y_nxt     = w_sample;
`endif
                end
            end

            S_DONE: begin
                // busy spans the result cycle so it frames the full
                // transaction, including the y_valid pulse.
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cs_n_nxt  = 1'b1;
                w_sclk_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_poll  <= '0;
            r_div   <= '0;
            r_half  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_sclk  <= 1'b1;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_y     <= 8'd128;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_poll  <= w_poll_nxt;
            r_div   <= w_div_nxt;
            r_half  <= w_half_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_sclk  <= w_sclk_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_mosi  <= w_mosi_nxt;
            r_busy  <= w_busy_nxt;
            r_y     <= w_y_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign sclk    = r_sclk;
    assign cs_n    = r_cs_n;
    assign mosi    = r_mosi;
    assign busy    = r_busy;
    assign y_angle = r_y;
    assign y_valid = r_valid;

endmodule
`default_nettype wire
